de_scoreboard: RTL and testbench

- Register-hazard controller for the decode stage. It tracks in-flight writes per architectural register and drives the DE stall that holds FE and inserts a bubble into the DE latch.
- It replaces ad-hoc busy bits with per-register saturating pending counters, so back-to-back writers to the same register are handled correctly.
- It sits beside the DE register file:
  - Issue events come from DE.
  - Retire events come from the WB-to-DE bus (wr_reg_WB, wregno_WB).

---
 rtl/de_scoreboard_pkg.sv | 6 +
 rtl/de_scoreboard_sb_counter.sv | 23 ++
 rtl/de_scoreboard.sv | 60 ++++++
 tb/tb_de_scoreboard.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/de_scoreboard_pkg.sv
// de_scoreboard_pkg: default sizing shared by the decode-stage register scoreboard.
package de_scoreboard_pkg;
    localparam int SB_NREGS     = 32;
    localparam int SB_REGNOBITS = 5;
    localparam int SB_CNTBITS   = 2;
endpackage

// File: rtl/de_scoreboard_sb_counter.sv
// de_scoreboard_sb_counter: saturating up/down pending-write counter with zero flag.
module de_scoreboard_sb_counter #(
    parameter int CNTBITS = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               dec,
    output logic [CNTBITS-1:0] count,
    output logic               zero
);
    logic [CNTBITS-1:0] cnt_d, cnt_q;
    logic               dn;
    always_comb begin
        dn    = dec && cnt_q != '0;
        cnt_d = reset ? '0 :
                (inc && !dn && cnt_q != '1) ? cnt_q + CNTBITS'(1) :
                (dn && !inc) ? cnt_q - CNTBITS'(1) : cnt_q;
    end
    always_ff @(posedge clk) cnt_q <= cnt_d;
    assign count = cnt_q;
    assign zero  = cnt_q == '0;
endmodule

// File: rtl/de_scoreboard.sv
// de_scoreboard: per-register pending-write scoreboard driving the DE stall.
// DE_SB_WB_BYPASS_EN lets a reader whose last pending writer retires this cycle proceed.
module de_scoreboard
    import de_scoreboard_pkg::*;
#(
    parameter int NREGS     = SB_NREGS,
    parameter int REGNOBITS = SB_REGNOBITS,
    parameter int CNTBITS   = SB_CNTBITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 src1_valid,
    input  logic [REGNOBITS-1:0] src1_regno,
    input  logic                 src2_valid,
    input  logic [REGNOBITS-1:0] src2_regno,
    input  logic                 de_valid,
    input  logic                 dst_wr,
    input  logic [REGNOBITS-1:0] dst_regno,
    input  logic                 wb_wr_reg,
    input  logic [REGNOBITS-1:0] wb_regno,
    output logic                 stall_DE,
    output logic                 issue,
    output logic [NREGS-1:0]     busy_vec,
    output logic                 sb_error
);
    logic [NREGS-1:0][CNTBITS-1:0] cnt;
    logic [NREGS-1:0]              zero;
    logic hz1, hz2, hzd, rel1, rel2, sb_error_d, sb_error_q;
    assign cnt[0]  = '0;
    assign zero[0] = 1'b1;
    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        de_scoreboard_sb_counter #(.CNTBITS(CNTBITS)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (issue && dst_wr && dst_regno == REGNOBITS'(r)),
            .dec   (wb_wr_reg && wb_regno == REGNOBITS'(r)),
            .count (cnt[r]),
            .zero  (zero[r])
        );
    end
`ifdef DE_SB_WB_BYPASS_EN
    assign rel1 = wb_wr_reg && wb_regno == src1_regno && cnt[src1_regno] == CNTBITS'(1);
    assign rel2 = wb_wr_reg && wb_regno == src2_regno && cnt[src2_regno] == CNTBITS'(1);
`else
    assign rel1 = 1'b0;
    assign rel2 = 1'b0;
`endif
    always_comb begin
        hz1        = src1_valid && src1_regno != '0 && !zero[src1_regno] && !rel1;
        hz2        = src2_valid && src2_regno != '0 && !zero[src2_regno] && !rel2;
        hzd        = dst_wr && dst_regno != '0 && &cnt[dst_regno];
        stall_DE   = de_valid && (hz1 || hz2 || hzd);
        issue      = de_valid && !stall_DE;
        // a retire with nothing pending is a pipeline bookkeeping bug; latch it
        sb_error_d = reset ? 1'b0 : sb_error_q || (wb_wr_reg && wb_regno != '0 && zero[wb_regno]);
    end
    always_ff @(posedge clk) sb_error_q <= sb_error_d;
    assign busy_vec = ~zero;
    assign sb_error = sb_error_q;
endmodule

// File: tb/tb_de_scoreboard.sv
// tb_de_scoreboard: directed and randomized checks against a pending-count model.
module tb_de_scoreboard;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic src1_valid = 0, src2_valid = 0, de_valid = 0, dst_wr = 0, wb_wr_reg = 0;
    logic [4:0] src1_regno = 0, src2_regno = 0, dst_regno = 0, wb_regno = 0;
    logic stall_DE, issue, sb_error;
    logic [31:0] busy_vec;
    int mc[32];
    bit merr;
    int checks = 0, fails = 0;
    always #5 clk = ~clk;
    de_scoreboard dut (
        .clk(clk), .reset(reset),
        .src1_valid(src1_valid), .src1_regno(src1_regno),
        .src2_valid(src2_valid), .src2_regno(src2_regno),
        .de_valid(de_valid), .dst_wr(dst_wr), .dst_regno(dst_regno),
        .wb_wr_reg(wb_wr_reg), .wb_regno(wb_regno),
        .stall_DE(stall_DE), .issue(issue), .busy_vec(busy_vec), .sb_error(sb_error)
    );
    function automatic int eff(input int r);
        int e = mc[r];
`ifdef DE_SB_WB_BYPASS_EN
        if (wb_wr_reg && int'(wb_regno) == r) e--;
`endif
        return e;
    endfunction
    function automatic bit exp_stall();
        bit h1 = src1_valid && src1_regno != 0 && eff(int'(src1_regno)) > 0;
        bit h2 = src2_valid && src2_regno != 0 && eff(int'(src2_regno)) > 0;
        bit hd = dst_wr && dst_regno != 0 && mc[dst_regno] == 3;
        return de_valid && (h1 || h2 || hd);
    endfunction
    function automatic logic [31:0] exp_busy();
        logic [31:0] b = '0;
        for (int i = 1; i < 32; i++) b[i] = mc[i] != 0;
        return b;
    endfunction
    task automatic set_in(input bit dv, input bit s1v, input int s1, input bit s2v, input int s2,
                          input bit dw, input int d, input bit wv, input int w);
        de_valid = dv; src1_valid = s1v; src1_regno = 5'(s1); src2_valid = s2v; src2_regno = 5'(s2);
        dst_wr = dw; dst_regno = 5'(d); wb_wr_reg = wv; wb_regno = 5'(w);
    endtask
    task automatic tick();
        bit iss = de_valid && !exp_stall();
        bit rst = reset;
        bit dw = dst_wr, wv = wb_wr_reg;
        int d = int'(dst_regno), w = int'(wb_regno);
        bit dec;
        @(posedge clk);
        if (rst) begin
            foreach (mc[i]) mc[i] = 0;
            merr = 0;
        end else begin
            if (wv && w != 0 && mc[w] == 0) merr = 1;
            dec = wv && w != 0 && mc[w] > 0;
            if (dec) mc[w]--;
            if (iss && dw && d != 0) mc[d]++;
        end
        #1;
    endtask
    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1;
        tick();
        reset = 0;
    endtask
    task automatic test_reset();
        reset = 1;
        tick(); tick();
        reset = 0;
        checks++; if (busy_vec !== 32'h0) begin fails++; $display("FAIL reset_busy: got %h want 0", busy_vec); end
        checks++; if (sb_error !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", sb_error); end
        set_in(1, 1, 1, 1, 2, 1, 5, 0, 0);
        #1;
        checks++; if (stall_DE !== 1'b0 || issue !== 1'b1) begin fails++; $display("FAIL first_issue: stall %b issue %b want 0 1", stall_DE, issue); end
        tick();
        checks++; if (busy_vec[5] !== 1'b1 || busy_vec !== exp_busy()) begin fails++; $display("FAIL busy5: got %h want %h", busy_vec, exp_busy()); end
    endtask
    task automatic test_raw_hazard();
        set_in(1, 1, 5, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (stall_DE !== 1'b1 || issue !== 1'b0) begin fails++; $display("FAIL raw_stall: stall %b issue %b want 1 0", stall_DE, issue); end
        wb_wr_reg = 1; wb_regno = 5;
        #1;
`ifdef DE_SB_WB_BYPASS_EN
        checks++; if (stall_DE !== 1'b0) begin fails++; $display("FAIL raw_bypass: got %b want 0", stall_DE); end
`else
        checks++; if (stall_DE !== 1'b1) begin fails++; $display("FAIL raw_retire_cycle: got %b want 1", stall_DE); end
`endif
        tick();
        wb_wr_reg = 0;
        #1;
        checks++; if (stall_DE !== 1'b0 || issue !== 1'b1) begin fails++; $display("FAIL raw_clear: stall %b issue %b want 0 1", stall_DE, issue); end
        checks++; if (busy_vec !== 32'h0) begin fails++; $display("FAIL raw_busy: got %h want 0", busy_vec); end
    endtask
    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 0, 0, 1, 7, 0, 0);
            #1;
            checks++; if (issue !== 1'b1) begin fails++; $display("FAIL sat_fill%0d: issue %b want 1", i, issue); end
            tick();
        end
        #1;
        checks++; if (stall_DE !== 1'b1 || issue !== 1'b0) begin fails++; $display("FAIL sat_hzd: stall %b issue %b want 1 0", stall_DE, issue); end
        wb_wr_reg = 1; wb_regno = 7;
        #1;
        checks++; if (stall_DE !== 1'b1) begin fails++; $display("FAIL sat_hzd_wb: got %b want 1", stall_DE); end
        tick();
        wb_wr_reg = 0;
        #1;
        checks++; if (stall_DE !== 1'b0 || issue !== 1'b1) begin fails++; $display("FAIL sat_fourth: stall %b issue %b want 0 1", stall_DE, issue); end
        tick();
        #1;
        checks++; if (stall_DE !== 1'b1) begin fails++; $display("FAIL sat_refull: got %b want 1", stall_DE); end
    endtask
    task automatic test_issue_retire();
        do_reset();
        set_in(1, 0, 0, 0, 0, 1, 9, 0, 0);
        tick();
        set_in(1, 0, 0, 0, 0, 1, 9, 1, 9);
        #1;
        checks++; if (issue !== 1'b1) begin fails++; $display("FAIL ir_issue: got %b want 1", issue); end
        tick();
        checks++; if (busy_vec[9] !== 1'b1) begin fails++; $display("FAIL ir_busy: got %b want 1", busy_vec[9]); end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 9);
        tick();
        checks++; if (busy_vec[9] !== 1'b0 || sb_error !== 1'b0) begin fails++; $display("FAIL ir_drain: busy %b err %b want 0 0", busy_vec[9], sb_error); end
    endtask
    task automatic test_reg0_error();
        do_reset();
        set_in(1, 1, 0, 0, 0, 1, 0, 1, 0);
        #1;
        checks++; if (stall_DE !== 1'b0) begin fails++; $display("FAIL r0_stall: got %b want 0", stall_DE); end
        tick();
        checks++; if (busy_vec !== 32'h0 || sb_error !== 1'b0) begin fails++; $display("FAIL r0_state: busy %h err %b want 0 0", busy_vec, sb_error); end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 12);
        tick();
        checks++; if (sb_error !== 1'b1 || busy_vec[12] !== 1'b0) begin fails++; $display("FAIL err_set: err %b busy %b want 1 0", sb_error, busy_vec[12]); end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
        checks++; if (sb_error !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", sb_error); end
        do_reset();
        checks++; if (sb_error !== 1'b0) begin fails++; $display("FAIL err_clear: got %b want 0", sb_error); end
    endtask
    task automatic test_reset_mid();
        do_reset();
        set_in(1, 0, 0, 0, 0, 1, 3, 0, 0);
        tick();
        dst_regno = 4;
        tick();
        checks++; if (busy_vec !== 32'h18) begin fails++; $display("FAIL mid_pending: got %h want 18", busy_vec); end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 12);
        reset = 1;
        tick();
        reset = 0;
        checks++; if (busy_vec !== 32'h0 || sb_error !== 1'b0) begin fails++; $display("FAIL mid_reset: busy %h err %b want 0 0", busy_vec, sb_error); end
        set_in(1, 1, 3, 0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (stall_DE !== 1'b0) begin fails++; $display("FAIL mid_reader: got %b want 0", stall_DE); end
    endtask
    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 2) == 0, $urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) reset = 1;
            #1;
            checks++; if (stall_DE !== exp_stall() || issue !== (de_valid && !exp_stall())) begin
                fails++; $display("FAIL rnd_comb[%0d]: stall %b issue %b want %b %b", n, stall_DE, issue, exp_stall(), de_valid && !exp_stall());
            end
            tick();
            reset = 0;
            checks++; if (busy_vec !== exp_busy() || sb_error !== merr) begin
                fails++; $display("FAIL rnd_state[%0d]: busy %h err %b want %h %b", n, busy_vec, sb_error, exp_busy(), merr);
            end
        end
    endtask
    initial begin
        foreach (mc[i]) mc[i] = 0;
        merr = 0;
        test_reset();
        test_raw_hazard();
        test_saturation();
        test_issue_retire();
        test_reg0_error();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
